// File: rtl/bitonic_sort_pipe.sv
// Fully pipelined bitonic sorting network, one register stage per network column.
// Define BITONIC_SORT_INDEX_EN to add the out_idx port (original lane of each key).
module bitonic_sort_pipe #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned N_ELEMS = 8
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [N_ELEMS*WIDTH-1:0]              in_data,
  input  logic                                  in_dir,
  output logic                                  out_valid,
  output logic [N_ELEMS*WIDTH-1:0]              out_data,
  output logic                                  out_dir,
`ifdef BITONIC_SORT_INDEX_EN
  output logic [N_ELEMS*$clog2(N_ELEMS)-1:0]    out_idx,
`endif
  input  logic                                  out_ready
);

  localparam int LOG_N  = $clog2(N_ELEMS);
  localparam int STAGES = LOG_N * (LOG_N + 1) / 2;
  localparam int DW     = N_ELEMS * WIDTH;

  logic [STAGES-1:0][DW-1:0] data_q, src_data, net_data;
  logic [STAGES-1:0]         dir_q, v_q, src_dir, src_v, adv;

`ifdef BITONIC_SORT_INDEX_EN
  localparam int IW = N_ELEMS * LOG_N;
  logic [STAGES-1:0][IW-1:0] idx_q, src_idx, net_idx;

  for (genvar i = 0; i < N_ELEMS; i++) begin : g_tag
    assign src_idx[0][i*LOG_N +: LOG_N] = LOG_N'(i);
  end
  for (genvar s = 1; s < STAGES; s++) begin : g_idx_src
    assign src_idx[s] = idx_q[s-1];
  end
`endif

  assign src_data[0] = in_data;
  assign src_dir[0]  = in_dir;
  assign src_v[0]    = in_valid;
  for (genvar s = 1; s < STAGES; s++) begin : g_src
    assign src_data[s] = data_q[s-1];
    assign src_dir[s]  = dir_q[s-1];
    assign src_v[s]    = v_q[s-1];
  end

  // Stage S implements column (k = 2^p, j = 2^(q-1)) of the network.
  for (genvar p = 1; p <= LOG_N; p++) begin : g_k
    for (genvar q = p; q >= 1; q--) begin : g_j
      localparam int S = p * (p - 1) / 2 + (p - q);
      localparam int K = 1 << p;
      localparam int J = 1 << (q - 1);
      for (genvar i = 0; i < N_ELEMS; i++) begin : g_lane
        if ((i & J) == 0) begin : g_cs
          localparam int L = i | J;
          logic [WIDTH-1:0] key_a, key_b;
          logic             up, swap;
          assign key_a = src_data[S][i*WIDTH +: WIDTH];
          assign key_b = src_data[S][L*WIDTH +: WIDTH];
          assign up    = (((i & K) == 0) == src_dir[S]);
          // Strict compares: equal keys never swap.
          assign swap  = up ? (key_a > key_b) : (key_a < key_b);
          assign net_data[S][i*WIDTH +: WIDTH] = swap ? key_b : key_a;
          assign net_data[S][L*WIDTH +: WIDTH] = swap ? key_a : key_b;
`ifdef BITONIC_SORT_INDEX_EN
          assign net_idx[S][i*LOG_N +: LOG_N] =
              swap ? src_idx[S][L*LOG_N +: LOG_N] : src_idx[S][i*LOG_N +: LOG_N];
          assign net_idx[S][L*LOG_N +: LOG_N] =
              swap ? src_idx[S][i*LOG_N +: LOG_N] : src_idx[S][L*LOG_N +: LOG_N];
`endif
        end
      end
    end
  end

  // Stage s may load unless it and every stage after it is full while out_ready is low.
  always_comb begin
    adv = '0;
    for (int s = 0; s < STAGES; s++) begin
      logic all_v;
      all_v = 1'b1;
      for (int t = s; t < STAGES; t++) all_v = all_v & v_q[t];
      adv[s] = out_ready || !all_v;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v_q    <= '0;
      dir_q  <= '0;
      data_q <= '0;
    end else begin
      for (int s = 0; s < STAGES; s++) begin
        if (adv[s]) begin
          v_q[s] <= src_v[s];
          if (src_v[s]) begin
            data_q[s] <= net_data[s];
            dir_q[s]  <= src_dir[s];
          end
        end
      end
    end
  end

`ifdef BITONIC_SORT_INDEX_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx_q <= '0;
    end else begin
      for (int s = 0; s < STAGES; s++) begin
        if (adv[s] && src_v[s]) idx_q[s] <= net_idx[s];
      end
    end
  end
  assign out_idx = idx_q[STAGES-1];
`endif

  assign in_ready  = adv[0];
  assign out_valid = v_q[STAGES-1];
  assign out_data  = data_q[STAGES-1];
  assign out_dir   = dir_q[STAGES-1];

endmodule

// File: tb/tb_bitonic_sort_pipe.sv
// Scoreboard bench for bitonic_sort_pipe at default parameters (32-bit keys, 8 lanes).
module tb_bitonic_sort_pipe;
  localparam int W      = 32;
  localparam int N      = 8;
  localparam int LOGN   = 3;
  localparam int STAGES = 6;
  localparam int DW     = N * W;

  logic          clk, rst_n, in_valid, in_ready, in_dir, out_valid, out_dir, out_ready;
  logic [DW-1:0] in_data, out_data;
`ifdef BITONIC_SORT_INDEX_EN
  logic [N*LOGN-1:0] out_idx;
`endif

  bitonic_sort_pipe #(.WIDTH(W), .N_ELEMS(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_dir    (in_dir),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_dir   (out_dir),
`ifdef BITONIC_SORT_INDEX_EN
    .out_idx   (out_idx),
`endif
    .out_ready (out_ready)
  );

  typedef struct {
    logic [DW-1:0] din;
    logic          dir;
    int            c;
    bit            lat;
  } exp_t;

  exp_t          sb[$];
  int            total = 0, bad = 0, cyc = 0;
  bit            lat_en = 1'b1;
  bit            held_v = 1'b0;
  logic [DW-1:0] held_d;
  logic          held_dir;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] model(input logic [DW-1:0] v, input logic dir);
    logic [W-1:0]  k [N];
    logic [W-1:0]  t;
    logic [DW-1:0] r;
    for (int i = 0; i < N; i++) k[i] = v[i*W +: W];
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N - 1 - i; j++)
        if (k[j] > k[j+1]) begin
          t = k[j]; k[j] = k[j+1]; k[j+1] = t;
        end
    for (int i = 0; i < N; i++) r[i*W +: W] = dir ? k[i] : k[N-1-i];
    return r;
  endfunction

  function automatic logic [DW-1:0] mk(input logic [W-1:0] a0, a1, a2, a3, a4, a5, a6, a7);
    return {a7, a6, a5, a4, a3, a2, a1, a0};
  endfunction

  function automatic logic [DW-1:0] rnd_vec(input int range);
    logic [DW-1:0] r;
    for (int i = 0; i < N; i++) r[i*W +: W] = (range == 0) ? $urandom : $urandom_range(range);
    return r;
  endfunction

  // Output monitor: pops the scoreboard on every output handshake.
  always @(negedge clk) begin
    if (!rst_n) begin
      held_v = 1'b0;
    end else begin
      if (held_v) begin
        check("hold_valid", DW'(out_valid), DW'(1));
        check("hold_data", out_data, held_d);
        check("hold_dir", DW'(out_dir), DW'(held_dir));
      end
      held_v   = out_valid && !out_ready;
      held_d   = out_data;
      held_dir = out_dir;
      if (out_valid && out_ready) begin
        check("unexpected_out", DW'(sb.size() != 0), DW'(1));
        if (sb.size() != 0) begin
          exp_t e;
          e = sb.pop_front();
          check("data", out_data, model(e.din, e.dir));
          check("dir", DW'(out_dir), DW'(e.dir));
          if (e.lat) check("latency", DW'(cyc - e.c), DW'(STAGES));
`ifdef BITONIC_SORT_INDEX_EN
          begin
            logic [DW-1:0]     mapped;
            logic [N*LOGN-1:0] ident;
            bit                ties = 1'b1;
            for (int i = 0; i < N; i++) begin
              mapped[i*W +: W]   = e.din[int'(out_idx[i*LOGN +: LOGN])*W +: W];
              ident[i*LOGN +: LOGN] = LOGN'(i);
              if (e.din[i*W +: W] != e.din[W-1:0]) ties = 1'b0;
            end
            check("idx_map", mapped, out_data);
            if (ties) check("idx_ties", DW'(out_idx), DW'(ident));
          end
`endif
        end
      end
    end
  end

  task automatic send(input logic [DW-1:0] d, input logic dr);
    bit ok = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_dir   = dr;
    for (int t = 0; t < 200 && !ok; t++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_t e;
        e.din = d; e.dir = dr; e.c = cyc; e.lat = lat_en;
        sb.push_back(e);
        ok = 1'b1;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("send_timeout", DW'(ok), DW'(1));
  endtask

  task automatic drain();
    for (int t = 0; t < 100 && sb.size() != 0; t++) @(negedge clk);
    check("drain", DW'(sb.size()), DW'(0));
    @(posedge clk); #1;
  endtask

  initial begin
    logic [DW-1:0] v1, vr [10];
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_dir = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_out_valid", DW'(out_valid), DW'(0));
    check("rst_out_data", out_data, '0);
    check("rst_out_dir", DW'(out_dir), DW'(0));
    check("rst_in_ready", DW'(in_ready), DW'(1));
    @(posedge clk); #1;

    // Directed ascending / descending vectors.
    out_ready = 1'b1;
    v1 = mk(7, 3, 5, 1, 8, 2, 6, 4);
    send(v1, 1'b1);
    drain();
    send(v1, 1'b0);
    drain();
    for (int i = 0; i < 6; i++) send(v1, i[0] ? 1'b0 : 1'b1);
    drain();

    // Ties and unsigned extremes.
    send(mk(5, 5, 5, 5, 5, 5, 5, 5), 1'b1);
    send(mk(32'hFFFF_FFFF, 0, 32'h8000_0000, 1, 32'h7FFF_FFFF, 0, 32'hFFFF_FFFE, 2), 1'b1);
    drain();

    // Backpressure: fill all stages, confirm in_ready drops, then release.
    lat_en = 1'b0;
    for (int i = 0; i < 10; i++) vr[i] = rnd_vec(i[0] ? 4 : 0);
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) send(vr[i], i[1]);
    in_valid = 1'b1; in_data = vr[6]; in_dir = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("full_in_ready", DW'(in_ready), DW'(0));
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    for (int i = 6; i < 10; i++) send(vr[i], i[0]);
    drain();
    lat_en = 1'b1;

    // Reset with vectors in flight.
    for (int i = 0; i < 3; i++) send(rnd_vec(0), 1'b1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    sb.delete();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("flush_out_valid", DW'(out_valid), DW'(0));
    end
    @(posedge clk); #1;
    send(mk(9, 8, 7, 6, 5, 4, 3, 2), 1'b1);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end
endmodule
